// File: rtl/rpds_array.sv
// Per-drive RPDS status state for NDRV drives behind one massbus interface.
// Latency: ds and as are combinational from state; atnIRQ lags as by one clock.
// Backpressure: none; all strobes are single-cycle and always accepted.
module rpds_array #(
    parameter int NDRV = 8,
    parameter int SELW = 3,
    parameter int DBNC = 16,
    parameter int DBW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic [SELW-1:0] sel,
    input  logic [NDRV-1:0] cd,
    input  logic [NDRV-1:0] wp,
    input  logic [NDRV-1:0] dpr,
    input  logic [NDRV-1:0] pip,
    input  logic [NDRV-1:0] dry,
    input  logic [NDRV-1:0] err,
    input  logic [NDRV-1:0] go,
    input  logic [NDRV-1:0] setATA,
    input  logic [NDRV-1:0] setLST,
    input  logic [NDRV-1:0] daWRITE,
    input  logic [NDRV-1:0] drvclr,
    input  logic [NDRV-1:0] preset,
    input  logic [NDRV-1:0] pakack,
    input  logic            asWRITE,
    input  logic [NDRV-1:0] asDATA,
    output logic [15:0]     ds,
    output logic [NDRV-1:0] as,
    output logic            atnIRQ
);

    // Card-detect synchronizer; sync2_q is the usable, metastability-safe copy.
    logic [NDRV-1:0] sync1_q, sync2_q;

    // Debounce state and the debounced media-on-line level.
    logic [DBW-1:0]  cnt_q [NDRV];
    logic [DBW-1:0]  cnt_d [NDRV];
    logic [NDRV-1:0] mol_q, mol_d;
    logic [NDRV-1:0] lastmol_q;

    // Drive status bits.
    logic [NDRV-1:0] ata_q, ata_d;
    logic [NDRV-1:0] lst_q, lst_d;
    logic [NDRV-1:0] vv_q, vv_d;
    logic            atn_q;

    // A change of mol in either direction is a one-cycle event.
    logic [NDRV-1:0] mol_evt;
    logic [NDRV-1:0] ata_set;

    assign mol_evt = mol_q ^ lastmol_q;
    assign ata_set = setATA | mol_evt | (go & err);

    // Debounce: mol only follows s after it has differed for DBNC consecutive clocks.
    always_comb begin
        mol_d = mol_q;
        cnt_d = cnt_q;
        for (int i = 0; i < NDRV; i++) begin
            if (sync2_q[i] == mol_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DBW'(DBNC - 1)) begin
                mol_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Status bit next-state; a set of ATA beats a same-cycle RPAS clear so no event is lost.
    always_comb begin
        ata_d = ata_q;
        lst_d = lst_q;
        vv_d  = vv_q;
        for (int i = 0; i < NDRV; i++) begin
            if (clr || drvclr[i]) begin
                ata_d[i] = 1'b0;
            end else if (ata_set[i]) begin
                ata_d[i] = 1'b1;
            end else if (asWRITE && asDATA[i]) begin
                ata_d[i] = 1'b0;
            end

            if (clr || daWRITE[i]) begin
                lst_d[i] = 1'b0;
            end else if (setLST[i]) begin
                lst_d[i] = 1'b1;
            end

            // Pack going on or off line both invalidate the volume; clr leaves VV alone.
            if (mol_evt[i]) begin
                vv_d[i] = 1'b0;
            end else if ((preset[i] || pakack[i]) && !err[i]) begin
                vv_d[i] = 1'b1;
            end
        end
    end

    // State registers, asynchronously cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            mol_q     <= '0;
            lastmol_q <= '0;
            ata_q     <= '0;
            lst_q     <= '0;
            vv_q      <= '0;
            atn_q     <= 1'b0;
            for (int i = 0; i < NDRV; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= cd;
            sync2_q   <= sync1_q;
            mol_q     <= mol_d;
            lastmol_q <= mol_q;
            ata_q     <= ata_d;
            lst_q     <= lst_d;
            vv_q      <= vv_d;
            atn_q     <= |ata_q;
            for (int i = 0; i < NDRV; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // RPDS word of the selected drive; selects with no drive behind them read zero.
    always_comb begin
        ds = 16'h0000;
        for (int i = 0; i < NDRV; i++) begin
            if (sel == SELW'(i)) begin
                ds = {ata_q[i], err[i], pip[i], mol_q[i], wp[i], lst_q[i], 1'b0,
                      dpr[i], dry[i], vv_q[i], 6'b000000};
            end
        end
    end

    assign as     = ata_q;
    assign atnIRQ = atn_q;

endmodule

// File: tb/tb_rpds_array.sv
module tb_rpds_array;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic [2:0] sel;
    logic [7:0] cd, wp, dpr, pip, dry, err, go, setATA, setLST;
    logic [7:0] daWRITE, drvclr, preset, pakack, asDATA;
    logic       asWRITE;
    logic [15:0] ds;
    logic [7:0]  as;
    logic        atnIRQ;

    // Second instance with fewer drives than select codes.
    logic [2:0]  sel6;
    logic [15:0] ds6;
    logic [5:0]  as6;
    logic        atnIRQ6;

    int nchecks = 0;
    int nerrs   = 0;

    always #5 clk = ~clk;

    rpds_array #(.NDRV(8), .SELW(3), .DBNC(4), .DBW(3)) dut (
        .clk(clk), .rst(rst), .clr(clr), .sel(sel), .cd(cd), .wp(wp), .dpr(dpr),
        .pip(pip), .dry(dry), .err(err), .go(go), .setATA(setATA), .setLST(setLST),
        .daWRITE(daWRITE), .drvclr(drvclr), .preset(preset), .pakack(pakack),
        .asWRITE(asWRITE), .asDATA(asDATA), .ds(ds), .as(as), .atnIRQ(atnIRQ)
    );

    rpds_array #(.NDRV(6), .SELW(3), .DBNC(4), .DBW(3)) dut6 (
        .clk(clk), .rst(rst), .clr(1'b0), .sel(sel6), .cd(6'h00), .wp(6'h3F),
        .dpr(6'h00), .pip(6'h00), .dry(6'h3F), .err(6'h00), .go(6'h00),
        .setATA(6'h00), .setLST(6'h00), .daWRITE(6'h00), .drvclr(6'h00),
        .preset(6'h00), .pakack(6'h00), .asWRITE(1'b0), .asDATA(6'h00),
        .ds(ds6), .as(as6), .atnIRQ(atnIRQ6)
    );

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrs++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; sel = 3'd0; sel6 = 3'd0;
        cd = '0; wp = '0; dpr = '0; pip = '0; dry = '0; err = '0; go = '0;
        setATA = '0; setLST = '0; daWRITE = '0; drvclr = '0; preset = '0;
        pakack = '0; asWRITE = 1'b0; asDATA = '0;

        tick(2);
        check("reset_ds", 32'(ds), 32'h0000);
        check("reset_as", 32'(as), 32'h00);
        check("reset_irq", 32'(atnIRQ), 32'h0);
        rst = 1'b0;
        tick(1);

        // Card inserted on drive 0; edge numbering starts at the next edge.
        cd = 8'h01;
        tick(5);
        check("mol_before_e6", 32'(ds[12]), 32'h0);
        tick(1);
        check("mol_at_e6", 32'(ds), 32'h1000);
        check("as_at_e6", 32'(as), 32'h00);
        tick(1);
        check("as_at_e7", 32'(as), 32'h01);
        check("irq_at_e7", 32'(atnIRQ), 32'h0);
        tick(1);
        check("irq_at_e8", 32'(atnIRQ), 32'h1);
        dry = 8'h01; dpr = 8'h01;
        #1;
        check("ds0_online", 32'(ds), 32'h9180);

        // Acknowledge attention, validate the volume on drive 0.
        asWRITE = 1'b1; asDATA = 8'h01; pakack = 8'h01;
        tick(1);
        asWRITE = 1'b0; asDATA = 8'h00; pakack = 8'h00;
        check("as_w1c_0", 32'(as), 32'h00);
        check("ds0_vv", 32'(ds), 32'h11C0);

        // 3-cycle dropout is filtered.
        cd = 8'h00;
        tick(3);
        cd = 8'h01;
        tick(12);
        check("glitch3_ds", 32'(ds), 32'h11C0);
        check("glitch3_as", 32'(as), 32'h00);

        // 4-cycle dropout takes the pack off line.
        cd = 8'h00;
        tick(4);
        cd = 8'h01;
        tick(3);
        check("drop4_ds", 32'(ds), 32'h8180);
        check("drop4_as", 32'(as), 32'h01);
        tick(10);
        asWRITE = 1'b1; asDATA = 8'h01;
        tick(1);
        asWRITE = 1'b0; asDATA = 8'h00;
        dry = 8'h00; dpr = 8'h00;
        check("drop4_clear", 32'(as), 32'h00);

        // Pack acknowledge with and without error.
        pakack = 8'h04;
        tick(1);
        pakack = 8'h00;
        sel = 3'd2;
        #1;
        check("vv2_set", 32'(ds), 32'h0040);
        err = 8'h40; pakack = 8'h40;
        tick(1);
        pakack = 8'h00;
        sel = 3'd6;
        #1;
        check("vv6_err_blocked", 32'(ds), 32'h4000);
        err = 8'h00;

        // Attention summary: multi-drive set, w1c, set-wins, drive clear.
        setATA = 8'h0A;
        tick(1);
        setATA = 8'h00;
        check("as_set13", 32'(as), 32'h0A);
        asWRITE = 1'b1; asDATA = 8'h02;
        tick(1);
        check("as_w1c_1", 32'(as), 32'h08);
        asDATA = 8'h08; setATA = 8'h08;
        tick(1);
        asWRITE = 1'b0; asDATA = 8'h00; setATA = 8'h00;
        check("as_setwins", 32'(as), 32'h08);
        check("irq_on", 32'(atnIRQ), 32'h1);
        drvclr = 8'h08;
        tick(1);
        drvclr = 8'h00;
        check("as_drvclr", 32'(as), 32'h00);
        check("irq_lag", 32'(atnIRQ), 32'h1);
        tick(1);
        check("irq_off", 32'(atnIRQ), 32'h0);

        // LST set, clear by RPDA write, clr dominates set.
        setLST = 8'h20;
        tick(1);
        setLST = 8'h00;
        sel = 3'd5;
        #1;
        check("lst5_set", 32'(ds), 32'h0400);
        daWRITE = 8'h20;
        tick(1);
        daWRITE = 8'h00;
        check("lst5_daw", 32'(ds), 32'h0000);
        setLST = 8'h20; clr = 1'b1;
        tick(1);
        setLST = 8'h00; clr = 1'b0;
        check("lst5_clr", 32'(ds), 32'h0000);
        sel = 3'd2;
        #1;
        check("vv2_survives_clr", 32'(ds), 32'h0040);

        // GO with error raises attention.
        go = 8'h10; err = 8'h10;
        tick(1);
        go = 8'h00;
        sel = 3'd4;
        #1;
        check("go_err_ds", 32'(ds), 32'hC000);
        check("go_err_as", 32'(as), 32'h10);
        err = 8'h00;

        // Out-of-range selects on the 6-drive instance.
        sel6 = 3'd5;
        #1;
        check("ds6_sel5", 32'(ds6), 32'h0880);
        sel6 = 3'd6;
        #1;
        check("ds6_sel6", 32'(ds6), 32'h0000);
        sel6 = 3'd7;
        #1;
        check("ds6_sel7", 32'(ds6), 32'h0000);

        $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
        $finish;
    end

endmodule
